// File: rtl/rs_encoder_15_11_if.sv
// Stream interface for the RS(15,11) encoder: data symbols in, codeword symbols out.
// The IN_ABORT signal exists only when RS_ENC_ABORT_EN is defined.
interface rs_encoder_15_11_if;
   localparam int unsigned SYM_W = 4;

   logic             IN_VALID;
   logic [SYM_W-1:0] IN_SYMBOL;
   logic             IN_READY;
   logic             OUT_VALID;
   logic [SYM_W-1:0] OUT_SYMBOL;
   logic             OUT_SOF;
   logic             OUT_EOF;
   logic             OUT_READY;
`ifdef RS_ENC_ABORT_EN
   logic             IN_ABORT;
`endif

   modport slave (
`ifdef RS_ENC_ABORT_EN
      input  IN_ABORT,
`endif
      input  IN_VALID, IN_SYMBOL, OUT_READY,
      output IN_READY, OUT_VALID, OUT_SYMBOL, OUT_SOF, OUT_EOF
   );

   modport master (
`ifdef RS_ENC_ABORT_EN
      output IN_ABORT,
`endif
      output IN_VALID, IN_SYMBOL, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_SYMBOL, OUT_SOF, OUT_EOF
   );
endinterface

// File: rtl/rs_encoder_15_11.sv
// Systematic RS(15,11) encoder over GF(16), p(x)=x^4+x+1: echoes 11 data symbols, then 4 LFSR parity symbols.
// Optional feature macro: RS_ENC_ABORT_EN (adds synchronous frame abort via IN_ABORT).
module rs_encoder_15_11 (
   input  logic                CLK,
   input  logic                RESET_GLOBAL,
   rs_encoder_15_11_if.slave   bus
);
   localparam int unsigned SYM_W = 4;
   localparam int unsigned N     = 15;
   localparam int unsigned K     = 11;
   localparam int unsigned PAR   = N - K;
   localparam int unsigned CNT_W = 4;

   localparam logic [SYM_W-1:0] G3 = 4'hD;
   localparam logic [SYM_W-1:0] G2 = 4'hC;
   localparam logic [SYM_W-1:0] G1 = 4'h8;
   localparam logic [SYM_W-1:0] G0 = 4'h7;

   typedef enum logic {ST_DATA, ST_PARITY} state_t;

   // Multiply by alpha, reducing x^4 back to x+1.
   function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] a);
      return {a[SYM_W-2:0], 1'b0} ^ (a[SYM_W-1] ? 4'h3 : 4'h0);
   endfunction

   // Shift-and-add multiply; with a constant operand this folds to an XOR network.
   function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                               input logic [SYM_W-1:0] b);
      logic [SYM_W-1:0] acc;
      logic [SYM_W-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < SYM_W; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = gf_xtime(sh);
      end
      return acc;
   endfunction

   state_t                      r_state;
   logic [CNT_W-1:0]            r_count;
   logic [PAR-1:0][SYM_W-1:0]   r_lfsr;
   logic                        r_out_valid;
   logic [SYM_W-1:0]            r_out_symbol;
   logic                        r_out_sof;
   logic                        r_out_eof;

   state_t                      w_state;
   logic [CNT_W-1:0]            w_count;
   logic [PAR-1:0][SYM_W-1:0]   w_lfsr;
   logic                        w_out_valid;
   logic [SYM_W-1:0]            w_out_symbol;
   logic                        w_out_sof;
   logic                        w_out_eof;
   logic [SYM_W-1:0]            w_fb;
   logic                        w_slot_free;
   logic                        w_in_ready;
   logic                        w_accept;
   logic                        w_abort;

`ifdef RS_ENC_ABORT_EN
   assign w_abort = bus.IN_ABORT;
`else
   assign w_abort = 1'b0;
`endif

   assign w_slot_free = !r_out_valid || bus.OUT_READY;
   assign w_in_ready  = (r_state == ST_DATA) && w_slot_free && !w_abort;
   assign w_accept    = w_in_ready && bus.IN_VALID;

   // Next-state, LFSR and output-register logic.
   always_comb begin
      w_state      = r_state;
      w_count      = r_count;
      w_lfsr       = r_lfsr;
      w_out_valid  = r_out_valid;
      w_out_symbol = r_out_symbol;
      w_out_sof    = r_out_sof;
      w_out_eof    = r_out_eof;
      w_fb         = '0;

      if (w_abort) begin
         w_state     = ST_DATA;
         w_count     = '0;
         w_lfsr      = '0;
         w_out_valid = 1'b0;
         w_out_sof   = 1'b0;
         w_out_eof   = 1'b0;
      end else begin
         case (r_state)
            ST_DATA: begin
               if (w_accept) begin
                  w_fb         = bus.IN_SYMBOL ^ r_lfsr[PAR-1];
                  w_lfsr[3]    = r_lfsr[2] ^ gf_mul(w_fb, G3);
                  w_lfsr[2]    = r_lfsr[1] ^ gf_mul(w_fb, G2);
                  w_lfsr[1]    = r_lfsr[0] ^ gf_mul(w_fb, G1);
                  w_lfsr[0]    = gf_mul(w_fb, G0);
                  w_out_symbol = bus.IN_SYMBOL;
                  w_out_valid  = 1'b1;
                  w_out_sof    = (r_count == '0);
                  w_out_eof    = 1'b0;
                  if (r_count == CNT_W'(K - 1)) begin
                     w_state = ST_PARITY;
                     w_count = '0;
                  end else begin
                     w_count = r_count + CNT_W'(1);
                  end
               end else if (w_slot_free) begin
                  w_out_valid = 1'b0;
                  w_out_sof   = 1'b0;
                  w_out_eof   = 1'b0;
               end
            end
            ST_PARITY: begin
               if (w_slot_free) begin
                  w_out_symbol = r_lfsr[PAR-1];
                  w_out_valid  = 1'b1;
                  w_out_sof    = 1'b0;
                  w_out_eof    = (r_count == CNT_W'(PAR - 1));
                  w_lfsr       = {r_lfsr[PAR-2:0], SYM_W'(0)};
                  if (r_count == CNT_W'(PAR - 1)) begin
                     w_state = ST_DATA;
                     w_count = '0;
                  end else begin
                     w_count = r_count + CNT_W'(1);
                  end
               end
            end
            default: w_state = ST_DATA;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET_GLOBAL) begin
      if (RESET_GLOBAL) begin
         r_state      <= ST_DATA;
         r_count      <= '0;
         r_lfsr       <= '0;
         r_out_valid  <= 1'b0;
         r_out_symbol <= '0;
         r_out_sof    <= 1'b0;
         r_out_eof    <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_count      <= w_count;
         r_lfsr       <= w_lfsr;
         r_out_valid  <= w_out_valid;
         r_out_symbol <= w_out_symbol;
         r_out_sof    <= w_out_sof;
         r_out_eof    <= w_out_eof;
      end
   end

   assign bus.IN_READY   = w_in_ready;
   assign bus.OUT_VALID  = r_out_valid;
   assign bus.OUT_SYMBOL = r_out_symbol;
   assign bus.OUT_SOF    = r_out_sof;
   assign bus.OUT_EOF    = r_out_eof;
endmodule

// File: tb/tb_rs_encoder_15_11.sv
// Scoreboard bench for rs_encoder_15_11: long-division parity model, syndrome check, stall/gap/reset scenarios.
module tb_rs_encoder_15_11;
   typedef struct {
      logic [3:0] sym;
      logic       sof;
      logic       eof;
      int         idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         stall_pct = 0;
   int         gap_pct   = 0;
   bit         mon_en    = 1'b0;
   exp_t       q[$];
   exp_t       h;
   logic [3:0] cw[15];
   logic [3:0] gpoly[5] = '{4'h1, 4'hD, 4'hC, 4'h8, 4'h7};
   logic       prev_stall = 1'b0;
   logic [5:0] prev_out;

   rs_encoder_15_11_if bus();

   rs_encoder_15_11 dut (.CLK(clk), .RESET_GLOBAL(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready with a configurable stall probability.
   always @(posedge clk) begin
      #1;
      bus.OUT_READY = ($urandom_range(99) >= stall_pct);
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   // Polynomial-basis multiply with explicit reduction by x^4+x+1.
   function automatic logic [3:0] tb_gmul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 4; i++)
         if (b[i]) p = p ^ (8'({4'h0, a}) << i);
      for (int k = 6; k >= 4; k--)
         if (p[k]) p = p ^ (8'h13 << (k - 4));
      return p[3:0];
   endfunction

   // Output monitor: compare every valid beat against the queue head, check stalls and syndromes.
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            total++;
            if ({bus.OUT_VALID, bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF} !== {1'b1, prev_out[5:0]})
               begin bad++; $display("FAIL stall_hold got=%b exp=%b", {bus.OUT_VALID, bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF}, {1'b1, prev_out}); end
         end
         if (bus.OUT_VALID === 1'b1) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_beat got=%h exp=none", bus.OUT_SYMBOL);
            end else begin
               h = q[0];
               total++;
               if ({bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF} !== {h.sym, h.sof, h.eof}) begin
                  bad++;
                  $display("FAIL beat%0d sym/sof/eof got=%h/%b/%b exp=%h/%b/%b", h.idx,
                           bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF, h.sym, h.sof, h.eof);
               end
               if (h.idx >= 10 && h.idx <= 13) begin
                  total++;
                  if (bus.IN_READY !== 1'b0) begin bad++; $display("FAIL parity_in_ready beat%0d got=%b exp=0", h.idx, bus.IN_READY); end
               end
               if (bus.OUT_READY === 1'b1) begin
                  void'(q.pop_front());
                  cw[h.idx] = bus.OUT_SYMBOL;
                  if (h.idx == 14) begin
                     logic [3:0] ap[5];
                     logic [3:0] s;
                     ap = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
                     for (int j = 1; j <= 4; j++) begin
                        s = 4'h0;
                        for (int i = 0; i < 15; i++) s = tb_gmul(s, ap[j]) ^ cw[i];
                        total++;
                        if (s !== 4'h0) begin bad++; $display("FAIL syndrome_S%0d got=%h exp=0", j, s); end
                     end
                  end
               end
            end
         end
         prev_stall = (bus.OUT_VALID === 1'b1) && (bus.OUT_READY !== 1'b1);
         prev_out   = {bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic drive_sym(input logic [3:0] s, output int t);
      bit ok;
      ok = 1'b0;
      t  = -1;
      bus.IN_VALID  = 1'b1;
      bus.IN_SYMBOL = s;
      for (int w = 0; w < 200 && !ok; w++) begin
         @(negedge clk);
         if (bus.IN_READY === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      bus.IN_VALID = 1'b0;
      if (ok) t = cyc;
      total++;
      if (!ok) begin bad++; $display("FAIL accept_timeout got=noaccept exp=accept sym=%h", s); end
   endtask

   // Push the model codeword, then drive the first n data symbols with optional gaps.
   task automatic send_frame(input logic [3:0] d[11], input int n, output int t0);
      logic [3:0] c[15];
      logic [3:0] coef;
      exp_t       e;
      int         t;
      for (int i = 0; i < 15; i++) c[i] = (i < 11) ? d[i] : 4'h0;
      for (int i = 0; i < 11; i++) begin
         coef = c[i];
         if (coef != 4'h0)
            for (int k = 0; k < 5; k++) c[i+k] = c[i+k] ^ tb_gmul(coef, gpoly[k]);
      end
      for (int i = 0; i < 15; i++) begin
         e.sym = (i < 11) ? d[i] : c[i];
         e.sof = (i == 0);
         e.eof = (i == 14);
         e.idx = i;
         q.push_back(e);
      end
      t0 = -1;
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < 20 && $urandom_range(99) < gap_pct; g++) begin @(posedge clk); #1; end
         drive_sym(d[i], t);
         if (i == 0) t0 = t;
      end
   endtask

   task automatic wait_drain();
      for (int w = 0; w < 500 && q.size() != 0; w++) @(posedge clk);
      #1;
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL drain_timeout got=%0d exp=0 pending", q.size()); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total++;
      if ({bus.OUT_VALID, bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF} !== 7'b0)
         begin bad++; $display("FAIL reset_outputs got=%b exp=0", {bus.OUT_VALID, bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF}); end
      rst = 1'b0;
      #1;
      total++;
      if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.IN_READY); end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_frame();
      logic [3:0] d[11];
      int t0;
      foreach (d[i]) d[i] = 4'h0;
      send_frame(d, 11, t0);
      wait_drain();
   endtask

   task automatic test_last_one();
      logic [3:0] d[11];
      logic [3:0] expp[4];
      int t0;
      foreach (d[i]) d[i] = 4'h0;
      d[10] = 4'h1;
      expp = '{4'hD, 4'hC, 4'h8, 4'h7};
      send_frame(d, 11, t0);
      wait_drain();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (cw[11+i] !== expp[i]) begin bad++; $display("FAIL last_one_parity%0d got=%h exp=%h", i, cw[11+i], expp[i]); end
      end
   endtask

   task automatic test_first_one();
      logic [3:0] d[11];
      int t0;
      foreach (d[i]) d[i] = 4'h0;
      d[0] = 4'h1;
      send_frame(d, 11, t0);
      wait_drain();
   endtask

   task automatic test_random();
      logic [3:0] d[11];
      int t0;
      stall_pct = 30;
      gap_pct   = 30;
      for (int f = 0; f < 6; f++) begin
         foreach (d[i]) d[i] = 4'($urandom_range(15));
         send_frame(d, 11, t0);
      end
      wait_drain();
      stall_pct = 0;
      gap_pct   = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [3:0] d[11];
      int ta, tb;
      foreach (d[i]) d[i] = 4'($urandom_range(15));
      send_frame(d, 11, ta);
      foreach (d[i]) d[i] = 4'($urandom_range(15));
      send_frame(d, 11, tb);
      total++;
      if (tb - ta != 15) begin bad++; $display("FAIL frame_period got=%0d exp=15", tb - ta); end
      wait_drain();
   endtask

   task automatic test_reset_mid();
      logic [3:0] d[11];
      int t0;
      foreach (d[i]) d[i] = 4'($urandom_range(15));
      send_frame(d, 6, t0);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.OUT_VALID, bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF} !== 7'b0)
         begin bad++; $display("FAIL midreset_outputs got=%b exp=0", {bus.OUT_VALID, bus.OUT_SYMBOL, bus.OUT_SOF, bus.OUT_EOF}); end
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      foreach (d[i]) d[i] = 4'($urandom_range(15));
      send_frame(d, 11, t0);
      wait_drain();
   endtask

`ifdef RS_ENC_ABORT_EN
   task automatic test_abort();
      logic [3:0] d[11];
      int t0;
      foreach (d[i]) d[i] = 4'($urandom_range(15));
      send_frame(d, 11, t0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.IN_ABORT = 1'b1;
      @(posedge clk); #1;
      bus.IN_ABORT = 1'b0;
      q.delete();
      total++;
      if ({bus.OUT_VALID, bus.OUT_EOF} !== 2'b00) begin bad++; $display("FAIL abort_parity got=%b exp=00", {bus.OUT_VALID, bus.OUT_EOF}); end
      foreach (d[i]) d[i] = 4'($urandom_range(15));
      send_frame(d, 3, t0);
      bus.IN_ABORT = 1'b1;
      #1;
      total++;
      if (bus.IN_READY !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b exp=0", bus.IN_READY); end
      @(posedge clk); #1;
      bus.IN_ABORT = 1'b0;
      q.delete();
      total++;
      if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL abort_data got=%b exp=0", bus.OUT_VALID); end
      foreach (d[i]) d[i] = 4'($urandom_range(15));
      send_frame(d, 11, t0);
      wait_drain();
   endtask
`endif

   initial begin
      rst           = 1'b1;
      bus.IN_VALID  = 1'b0;
      bus.IN_SYMBOL = 4'h0;
      bus.OUT_READY = 1'b1;
`ifdef RS_ENC_ABORT_EN
      bus.IN_ABORT  = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      mon_en = 1'b1;
      test_zero_frame();
      test_last_one();
      test_first_one();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef RS_ENC_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
